// File: rtl/ctrl_pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_sequencer
// Description : Decodes the ID opcode into a control bundle and carries it
//               through ID/EX, EX/MEM and MEM/WB. It also handles MUL/DIV
//               freezes, HALT/resume and bubbles for stalls and flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe_sequencer #(
    parameter int OPCODE_W   = 5,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                hazard_stall,
    input  logic                flush,
    input  logic                resume,
    output logic                id_jump,
    output logic                id_branch,
    output logic                id_mem_read,
    output logic                id_inc_pc,
    output logic                stall_out,
    output logic                ex_alu_src,
    output logic                ex_alu_op,
    output logic                ex_mem_read,
    output logic                mem_mem_write,
    output logic                mem_mem_read,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [1:0]          wb_write_mode,
    output logic                busy,
    output logic                halted
);

    // Opcode encodings as defined by the MINI-RISC parameters.v macro set.
    localparam logic [OPCODE_W-1:0] OP_ADD    = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_SUB    = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_MUL    = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_DIV    = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_NOT    = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_AND    = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_OR     = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_XOR    = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_INC    = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_CMP    = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_RR     = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_RL     = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_SETB   = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_CLRB   = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_CPLB   = OPCODE_W'(15);
    localparam logic [OPCODE_W-1:0] OP_SETF   = OPCODE_W'(16);
    localparam logic [OPCODE_W-1:0] OP_CLRF   = OPCODE_W'(17);
    localparam logic [OPCODE_W-1:0] OP_CPLF   = OPCODE_W'(18);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(19);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(20);
    localparam logic [OPCODE_W-1:0] OP_LBL    = OPCODE_W'(21);
    localparam logic [OPCODE_W-1:0] OP_LBH    = OPCODE_W'(22);
    localparam logic [OPCODE_W-1:0] OP_MOV    = OPCODE_W'(23);
    localparam logic [OPCODE_W-1:0] OP_JF     = OPCODE_W'(24);
    localparam logic [OPCODE_W-1:0] OP_LOADBR = OPCODE_W'(25);
    localparam logic [OPCODE_W-1:0] OP_MOVOUT = OPCODE_W'(26);
    localparam logic [OPCODE_W-1:0] OP_MOVIN  = OPCODE_W'(27);
    localparam logic [OPCODE_W-1:0] OP_MOVB   = OPCODE_W'(28);
    localparam logic [OPCODE_W-1:0] OP_HALT   = OPCODE_W'(29);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] write_mode;
        logic       branch;
        logic       jump;
        logic       mul;
        logic       div;
    } dec_t;

    typedef struct packed {
        logic       alu_src;
        logic       alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] write_mode;
        logic       mul;
        logic       div;
    } idex_t;

    typedef struct packed {
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] write_mode;
    } exmem_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [1:0] write_mode;
    } memwb_t;

    dec_t             dec;
    idex_t            idex_d, idex_q;
    exmem_t           exmem_d, exmem_q;
    memwb_t           memwb_d, memwb_q;
    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             is_halt, enter_busy, frozen, accept_ok, halt_set;

    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC, OP_CMP,
            OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB: begin
                dec.reg_write  = 1'b1;
                dec.alu_op     = 1'b1;
                dec.write_mode = 2'b01;
            end
            OP_DIV: begin
                dec.reg_write  = 1'b1;
                dec.alu_op     = 1'b1;
                dec.write_mode = 2'b01;
                dec.div        = 1'b1;
            end
            OP_MUL: begin
                dec.reg_write  = 1'b1;
                dec.alu_op     = 1'b1;
                dec.write_mode = 2'b11;
                dec.mul        = 1'b1;
            end
            OP_SETF, OP_CLRF, OP_CPLF: dec.alu_op = 1'b1;
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_read   = 1'b1;
                dec.write_mode = 2'b11;
            end
            OP_STORE: dec.mem_write = 1'b1;
            OP_LBL, OP_LBH: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.write_mode = 2'b01;
            end
            OP_MOV: begin
                dec.reg_write  = 1'b1;
                dec.write_mode = 2'b01;
            end
            OP_JF: begin
                dec.branch = 1'b1;
                dec.jump   = 1'b1;
            end
            OP_LOADBR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.write_mode = 2'b11;
            end
            OP_MOVOUT, OP_MOVIN, OP_MOVB: dec.reg_write = 1'b1;
            default: ;
        endcase
    end

    assign id_jump     = instr_valid & dec.jump;
    assign id_branch   = instr_valid & dec.branch;
    assign id_mem_read = instr_valid & dec.mem_read;

    assign is_halt    = instr_valid && (opcode == OP_HALT);
    assign enter_busy = (state_q == ST_IDLE) &&
                        ((idex_q.mul && (MUL_CYCLES > 1)) || (idex_q.div && (DIV_CYCLES > 1)));
    // The last BUSY cycle (cnt==0) is not frozen: its edge advances the pipe.
    assign frozen     = enter_busy || ((state_q == ST_BUSY) && (cnt_q != '0));
    assign accept_ok  = !frozen && !flush && !hazard_stall && instr_valid;
    assign halt_set   = accept_ok && is_halt;

    assign stall_out = frozen;
    assign busy      = (state_q == ST_BUSY);
    assign halted    = (state_q == ST_HALTED);
    assign id_inc_pc = !(stall_out | hazard_stall | halted | is_halt);

    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = '0;
        if (!frozen) begin
            idex_d = '0;
            if (accept_ok && !halted) begin
                idex_d.alu_src    = dec.alu_src;
                idex_d.alu_op     = dec.alu_op;
                idex_d.mem_read   = dec.mem_read;
                idex_d.mem_write  = dec.mem_write;
                idex_d.mem_to_reg = dec.mem_to_reg;
                idex_d.reg_write  = dec.reg_write;
                idex_d.write_mode = dec.write_mode;
                idex_d.mul        = dec.mul;
                idex_d.div        = dec.div;
            end
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.write_mode = idex_q.write_mode;
            memwb_d.reg_write  = exmem_q.reg_write;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.write_mode = exmem_q.write_mode;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enter_busy) begin
                    state_d = ST_BUSY;
                    cnt_d   = (idex_q.div && (DIV_CYCLES > 1)) ? DIV_LOAD : MUL_LOAD;
                end else if (halt_set) begin
                    state_d = ST_HALTED;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = halt_set ? ST_HALTED : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                if (!halt_set && resume) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alu_src    = idex_q.alu_src;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_mem_read   = idex_q.mem_read;
    assign mem_mem_write = exmem_q.mem_write;
    assign mem_mem_read  = exmem_q.mem_read;
    assign wb_reg_write  = memwb_q.reg_write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_write_mode = memwb_q.write_mode;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe_sequencer
// Description : Directed and random stimulus for ctrl_pipe_sequencer against
//               an instruction-token pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_sequencer;

    localparam int MC = 2;
    localparam int DC = 4;

    localparam int OP_ADD = 1,   OP_SUB = 2,    OP_MUL = 3,     OP_DIV = 4;
    localparam int OP_NOT = 5,   OP_AND = 6,    OP_OR = 7,      OP_XOR = 8;
    localparam int OP_INC = 9,   OP_CMP = 10,   OP_RR = 11,     OP_RL = 12;
    localparam int OP_SETB = 13, OP_CLRB = 14,  OP_CPLB = 15,   OP_SETF = 16;
    localparam int OP_CLRF = 17, OP_CPLF = 18,  OP_LOAD = 19,   OP_STORE = 20;
    localparam int OP_LBL = 21,  OP_LBH = 22,   OP_MOV = 23,    OP_JF = 24;
    localparam int OP_LOADBR = 25, OP_MOVOUT = 26, OP_MOVIN = 27, OP_MOVB = 28;
    localparam int OP_HALT = 29;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] opcode = '0;
    logic       instr_valid = 1'b0, hazard_stall = 1'b0, flush = 1'b0, resume = 1'b0;
    logic       id_jump, id_branch, id_mem_read, id_inc_pc, stall_out;
    logic       ex_alu_src, ex_alu_op, ex_mem_read, mem_mem_write, mem_mem_read;
    logic       wb_reg_write, wb_mem_to_reg, busy, halted;
    logic [1:0] wb_write_mode;

    int checks = 0;
    int failures = 0;

    ctrl_pipe_sequencer #(.OPCODE_W(5), .MUL_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
        .hazard_stall(hazard_stall), .flush(flush), .resume(resume),
        .id_jump(id_jump), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_inc_pc(id_inc_pc), .stall_out(stall_out), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_read(mem_mem_read), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_write_mode(wb_write_mode),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw, aop, asrc, mr, mw, m2r;
        logic [1:0] wm;
        logic       br, jp;
    } dec_t;

    // Control bundle of an instruction token; -1 stands for a bubble.
    function automatic dec_t dec(input int op);
        dec_t d = '0;
        if (op inside {OP_ADD, OP_SUB, OP_DIV, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC,
                       OP_CMP, OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB}) begin
            d.rw = 1'b1; d.aop = 1'b1; d.wm = 2'b01;
        end else if (op == OP_MUL) begin
            d.rw = 1'b1; d.aop = 1'b1; d.wm = 2'b11;
        end else if (op inside {OP_SETF, OP_CLRF, OP_CPLF}) begin
            d.aop = 1'b1;
        end else if (op == OP_LOAD) begin
            d.rw = 1'b1; d.m2r = 1'b1; d.mr = 1'b1; d.wm = 2'b11;
        end else if (op == OP_STORE) begin
            d.mw = 1'b1;
        end else if (op inside {OP_LBL, OP_LBH}) begin
            d.rw = 1'b1; d.asrc = 1'b1; d.wm = 2'b01;
        end else if (op == OP_MOV) begin
            d.rw = 1'b1; d.wm = 2'b01;
        end else if (op == OP_JF) begin
            d.br = 1'b1; d.jp = 1'b1;
        end else if (op == OP_LOADBR) begin
            d.rw = 1'b1; d.jp = 1'b1; d.wm = 2'b11;
        end else if (op inside {OP_MOVOUT, OP_MOVIN, OP_MOVB}) begin
            d.rw = 1'b1;
        end
        return d;
    endfunction

    function automatic int occ(input int op);
        if (op == OP_MUL) return MC;
        if (op == OP_DIV) return DC;
        return 1;
    endfunction

    // Model: which instruction sits in each stage and how long EX has held it.
    int   m_ex = -1, m_mem = -1, m_wb = -1, m_age = 0;
    logic m_halt = 1'b0;
    logic m_frz;
    logic fl_pend = 1'b0;

    always_comb m_frz = (m_age + 1) < occ(m_ex);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex <= -1; m_mem <= -1; m_wb <= -1; m_age <= 0; m_halt <= 1'b0;
        end else begin
            if (m_frz) begin
                m_age <= m_age + 1;
                m_wb  <= -1;
            end else begin
                m_wb  <= m_mem;
                m_mem <= m_ex;
                m_age <= 0;
                m_ex  <= (instr_valid && !flush && !hazard_stall && !m_halt &&
                          int'(opcode) != OP_HALT) ? int'(opcode) : -1;
            end
            if (!m_frz && !flush && !hazard_stall && instr_valid && int'(opcode) == OP_HALT)
                m_halt <= 1'b1;
            else if (resume)
                m_halt <= 1'b0;
        end
    end

    always @(posedge clk) fl_pend <= rst_n && flush && stall_out;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always begin
        dec_t di, de, dm, dw;
        @(negedge clk);
        #1;
        di = dec(int'(opcode));
        de = dec(m_ex);
        dm = dec(m_mem);
        dw = dec(m_wb);
        chk("id_jump",       int'(id_jump),       int'(instr_valid & di.jp));
        chk("id_branch",     int'(id_branch),     int'(instr_valid & di.br));
        chk("id_mem_read",   int'(id_mem_read),   int'(instr_valid & di.mr));
        chk("stall_out",     int'(stall_out),     int'(m_frz));
        chk("busy",          int'(busy),          int'(m_age >= 1));
        chk("halted",        int'(halted),        int'(m_halt));
        chk("id_inc_pc",     int'(id_inc_pc),     int'(!(m_frz || hazard_stall || m_halt ||
                                                         (instr_valid && int'(opcode) == OP_HALT))));
        chk("ex_alu_src",    int'(ex_alu_src),    int'(de.asrc));
        chk("ex_alu_op",     int'(ex_alu_op),     int'(de.aop));
        chk("ex_mem_read",   int'(ex_mem_read),   int'(de.mr));
        chk("mem_mem_write", int'(mem_mem_write), int'(dm.mw));
        chk("mem_mem_read",  int'(mem_mem_read),  int'(dm.mr));
        chk("wb_reg_write",  int'(wb_reg_write),  int'(dw.rw));
        chk("wb_mem_to_reg", int'(wb_mem_to_reg), int'(dw.m2r));
        chk("wb_write_mode", int'(wb_write_mode), int'(dw.wm));
        if (fl_pend) chk("flush_hold", int'(flush), 1);
    end

    task automatic drive(input int op, input logic v, input logic hz, input logic fl, input logic rs);
        opcode       = 5'(op);
        instr_valid  = v;
        hazard_stall = hz;
        flush        = fl;
        resume       = rs;
    endtask

    task automatic nxt(input int op, input logic v, input logic hz, input logic fl, input logic rs);
        @(negedge clk);
        drive(op, v, hz, fl, rs);
        #2;
    endtask

    // Issues op followed by a held instruction and counts the stall cycles.
    task automatic run_multi(input int op, input logic fl, output int nst);
        nst = 0;
        nxt(op, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(OP_ADD, 1'b1, 1'b0, fl, 1'b0);
        for (int k = 0; k < 12; k++) begin
            #2;
            if (stall_out) nst++;
            else break;
            @(negedge clk);
        end
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        #2;
        chk("lit_rst_busy",  int'(busy), 0);
        chk("lit_rst_stall", int'(stall_out), 0);
        chk("lit_rst_wbwm",  int'(wb_write_mode), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ADD, LOAD, STORE back to back
        nxt(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        nxt(OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_add_ex_alu_op", int'(ex_alu_op), 1);
        nxt(OP_STORE, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_load_ex_mem_read", int'(ex_mem_read), 1);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_add_wb_wm", int'(wb_write_mode), 1);
        chk("lit_load_mem_read", int'(mem_mem_read), 1);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_load_wb_wm", int'(wb_write_mode), 3);
        chk("lit_load_wb_m2r", int'(wb_mem_to_reg), 1);
        chk("lit_store_mem_write", int'(mem_mem_write), 1);
        repeat (3) nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // multi-cycle freezes
        run_multi(OP_DIV, 1'b0, n);
        chk("lit_div_stall_cycles", n, 3);
        repeat (3) nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_multi(OP_MUL, 1'b0, n);
        chk("lit_mul_stall_cycles", n, 1);
        repeat (3) nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // single hazard stall
        nxt(OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
        nxt(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit_hz_inc_pc", int'(id_inc_pc), 0);
        nxt(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_hz_inc_pc_after", int'(id_inc_pc), 1);
        chk("lit_hz_bubble", int'(ex_alu_op | ex_mem_read), 0);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_hz_add_ex", int'(ex_alu_op), 1);
        repeat (3) nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // HALT then resume
        nxt(OP_HALT, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_halt_inc_pc", int'(id_inc_pc), 0);
        nxt(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_halted_set", int'(halted), 1);
        repeat (4) nxt(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_halted_add_bubbled", int'(ex_alu_op), 0);
        nxt(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lit_halted_in_resume", int'(halted), 1);
        nxt(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_resumed", int'(halted), 0);
        chk("lit_resumed_inc_pc", int'(id_inc_pc), 1);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_add_after_resume", int'(ex_alu_op), 1);
        nxt(OP_HALT, 1'b1, 1'b0, 1'b0, 1'b0);
        nxt(OP_HALT, 1'b1, 1'b0, 1'b0, 1'b1);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_halt_set_wins", int'(halted), 1);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b1);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_halt_cleared", int'(halted), 0);

        // flush of the instruction behind JF, then flush held over a freeze
        nxt(OP_JF, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_jf_jump", int'(id_jump & id_branch), 1);
        nxt(OP_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_flush_bubble", int'(ex_alu_op), 0);
        repeat (2) nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_multi(OP_DIV, 1'b1, n);
        chk("lit_flush_div_stall", n, 3);
        chk("lit_flush_after_busy", int'(ex_alu_op), 0);
        repeat (3) nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-DIV at cnt=1
        nxt(OP_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_div_busy_before_rst", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_rst_mid_busy",  int'(busy), 0);
        chk("lit_rst_mid_stall", int'(stall_out | halted), 0);
        chk("lit_rst_mid_stages", int'({ex_alu_op, ex_mem_read, mem_mem_read, wb_reg_write,
                                        wb_write_mode}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        nxt(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_add_after_rst", int'(ex_alu_op), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = (i != 1500);
            if (fl_pend) begin
                // upstream keeps the flushed instruction and flush until released
            end else if (stall_out) begin
                hazard_stall = ($urandom_range(0, 7) == 0);
                resume       = ($urandom_range(0, 5) == 0);
            end else begin
                opcode       = 5'($urandom_range(0, 31));
                instr_valid  = ($urandom_range(0, 7) != 0);
                hazard_stall = ($urandom_range(0, 7) == 0);
                flush        = ($urandom_range(0, 11) == 0);
                resume       = ($urandom_range(0, 5) == 0);
            end
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
